vid_timing_gen_multi: RTL and testbench

Multi-mode video timing generator for the HDMI TX path. It replaces the fixed per-build video timing parameters with NUM_MODES timing presets held in parameters. The active preset is selectable at runtime, for example from board switches. A requested mode change is applied only at a frame boundary, so the downstream TMDS encoder and VDMA never see a torn frame.

---
 rtl/vid_timing_gen_multi_if.sv | 29 ++
 rtl/vid_timing_gen_multi.sv | 213 +++++++++++++++++++++
 tb/tb_vid_timing_gen_multi.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_timing_gen_multi_if.sv
// Video timing bundle: run/mode controls into the generator, per-pixel
// timing and mode status out of it.
interface vid_timing_gen_multi_if #(
  parameter int unsigned CW = 12
);
  logic          enable;
  logic [1:0]    mode_sel;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          frame_start;
  logic          line_start;
  logic [1:0]    mode_cur;
  logic          mode_pending;

  modport master (
    input  enable, mode_sel,
    output hsync, vsync, de, hcount, vcount,
    output frame_start, line_start, mode_cur, mode_pending
  );

  modport slave (
    output enable, mode_sel,
    input  hsync, vsync, de, hcount, vcount,
    input  frame_start, line_start, mode_cur, mode_pending
  );
endinterface

// File: rtl/vid_timing_gen_multi.sv
// Multi-preset raster timing generator; a requested mode switch is deferred
// to the frame boundary (or applied at once while idle) so frames never tear.
module vid_timing_gen_multi #(
  parameter int unsigned NUM_MODES    = 3,
  parameter int unsigned CW           = 12,
  parameter int unsigned DEFAULT_MODE = 0,
  parameter logic [NUM_MODES*CW-1:0] H_ACTIVE      = {12'd1920, 12'd1280, 12'd640},
  parameter logic [NUM_MODES*CW-1:0] H_FRONT_PORCH = {12'd88,   12'd110,  12'd16},
  parameter logic [NUM_MODES*CW-1:0] H_SYNC_WIDTH  = {12'd44,   12'd40,   12'd96},
  parameter logic [NUM_MODES*CW-1:0] H_BACK_PORCH  = {12'd148,  12'd220,  12'd48},
  parameter logic [NUM_MODES*CW-1:0] V_ACTIVE      = {12'd1080, 12'd720,  12'd480},
  parameter logic [NUM_MODES*CW-1:0] V_FRONT_PORCH = {12'd4,    12'd5,    12'd10},
  parameter logic [NUM_MODES*CW-1:0] V_SYNC_WIDTH  = {12'd5,    12'd5,    12'd2},
  parameter logic [NUM_MODES*CW-1:0] V_BACK_PORCH  = {12'd36,   12'd20,   12'd33},
  parameter logic [NUM_MODES-1:0]    HSYNC_POL     = 3'b110,
  parameter logic [NUM_MODES-1:0]    VSYNC_POL     = 3'b110
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vid_timing_gen_multi_if.master vid
);

  if (NUM_MODES < 1 || NUM_MODES > 4) begin : g_bad_num_modes
    $fatal(1, "NUM_MODES must be 1..4");
  end
  if (DEFAULT_MODE >= NUM_MODES) begin : g_bad_default
    $fatal(1, "DEFAULT_MODE out of range");
  end

  for (genvar g = 0; g < NUM_MODES; g++) begin : g_mode_chk
    localparam int unsigned HT_G = 32'(H_ACTIVE[g*CW +: CW]) + 32'(H_FRONT_PORCH[g*CW +: CW])
                                 + 32'(H_SYNC_WIDTH[g*CW +: CW]) + 32'(H_BACK_PORCH[g*CW +: CW]);
    localparam int unsigned VT_G = 32'(V_ACTIVE[g*CW +: CW]) + 32'(V_FRONT_PORCH[g*CW +: CW])
                                 + 32'(V_SYNC_WIDTH[g*CW +: CW]) + 32'(V_BACK_PORCH[g*CW +: CW]);
    localparam int unsigned LIMIT = 32'd1 << CW;
    if (HT_G > LIMIT || HT_G == 0) begin : g_bad_ht
      $fatal(1, "horizontal total does not fit the counter width");
    end
    if (VT_G > LIMIT || VT_G == 0) begin : g_bad_vt
      $fatal(1, "vertical total does not fit the counter width");
    end
  end

  localparam logic [1:0] RST_MODE = 2'(DEFAULT_MODE);
  localparam logic       RST_HS   = ~HSYNC_POL[DEFAULT_MODE];
  localparam logic       RST_VS   = ~VSYNC_POL[DEFAULT_MODE];

  typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_e;

  // Region edges, CW+1 bits so a total of exactly 2^CW is representable.
  typedef struct packed {
    logic [CW:0] ha;
    logic [CW:0] hss;
    logic [CW:0] hse;
    logic [CW:0] va;
    logic [CW:0] vss;
    logic [CW:0] vse;
    logic        hpol;
    logic        vpol;
  } edges_t;

  function automatic edges_t edges_of(input logic [1:0] m);
    edges_t e;
    e = '0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (m == 2'(i)) begin
        e.ha   = {1'b0, H_ACTIVE[i*CW +: CW]};
        e.hss  = e.ha  + {1'b0, H_FRONT_PORCH[i*CW +: CW]};
        e.hse  = e.hss + {1'b0, H_SYNC_WIDTH[i*CW +: CW]};
        e.va   = {1'b0, V_ACTIVE[i*CW +: CW]};
        e.vss  = e.va  + {1'b0, V_FRONT_PORCH[i*CW +: CW]};
        e.vse  = e.vss + {1'b0, V_SYNC_WIDTH[i*CW +: CW]};
        e.hpol = HSYNC_POL[i];
        e.vpol = VSYNC_POL[i];
      end
    end
    return e;
  endfunction

  function automatic logic [CW:0] ht_of(input logic [1:0] m);
    logic [CW:0] t;
    t = '0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (m == 2'(i)) begin
        t = {1'b0, H_ACTIVE[i*CW +: CW]} + {1'b0, H_FRONT_PORCH[i*CW +: CW]}
          + {1'b0, H_SYNC_WIDTH[i*CW +: CW]} + {1'b0, H_BACK_PORCH[i*CW +: CW]};
      end
    end
    return t;
  endfunction

  function automatic logic [CW:0] vt_of(input logic [1:0] m);
    logic [CW:0] t;
    t = '0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (m == 2'(i)) begin
        t = {1'b0, V_ACTIVE[i*CW +: CW]} + {1'b0, V_FRONT_PORCH[i*CW +: CW]}
          + {1'b0, V_SYNC_WIDTH[i*CW +: CW]} + {1'b0, V_BACK_PORCH[i*CW +: CW]};
      end
    end
    return t;
  endfunction

  state_e        st_q, st_d;
  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic [1:0]    mode_cur_q, mode_cur_d;
  logic [1:0]    pend_mode_q, pend_mode_d;
  logic          pend_q, pend_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          fs_q, fs_d;
  logic          ls_q, ls_d;

  logic          h_last, v_last, boundary, apply, hs_act, vs_act;
  edges_t        nxt_e;

  always_comb begin
    st_d        = vid.enable ? ST_RUN : ST_IDLE;
    h_last      = ({1'b0, hcount_q} == ht_of(mode_cur_q) - 1'b1);
    v_last      = ({1'b0, vcount_q} == vt_of(mode_cur_q) - 1'b1);
    boundary    = (st_q == ST_RUN) && h_last && v_last;
    apply       = pend_q && (boundary || !vid.enable);
    mode_cur_d  = apply ? pend_mode_q : mode_cur_q;
    pend_d      = apply ? 1'b0 : pend_q;
    pend_mode_d = pend_mode_q;

    // Compared against the mode in force after this edge, so a request made on
    // the boundary edge itself is queued for the following boundary.
    if (32'(vid.mode_sel) < NUM_MODES) begin
      if (vid.mode_sel != mode_cur_d) begin
        pend_d      = 1'b1;
        pend_mode_d = vid.mode_sel;
      end else begin
        pend_d      = 1'b0;
      end
    end

    hcount_d = '0;
    vcount_d = '0;
    if (vid.enable && st_q == ST_RUN) begin
      if (h_last) begin
        vcount_d = v_last ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
        vcount_d = vcount_q;
      end
    end

    // Decode the pixel being registered so every output describes it.
    nxt_e   = edges_of(mode_cur_d);
    hs_act  = ({1'b0, hcount_d} >= nxt_e.hss) && ({1'b0, hcount_d} < nxt_e.hse);
    vs_act  = ({1'b0, vcount_d} >= nxt_e.vss) && ({1'b0, vcount_d} < nxt_e.vse);
    de_d    = 1'b0;
    hsync_d = ~nxt_e.hpol;
    vsync_d = ~nxt_e.vpol;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    if (vid.enable) begin
      de_d    = ({1'b0, hcount_d} < nxt_e.ha) && ({1'b0, vcount_d} < nxt_e.va);
      hsync_d = ~(hs_act ^ nxt_e.hpol);
      vsync_d = ~(vs_act ^ nxt_e.vpol);
      ls_d    = (hcount_d == '0);
      fs_d    = (hcount_d == '0) && (vcount_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_IDLE;
      hcount_q    <= '0;
      vcount_q    <= '0;
      mode_cur_q  <= RST_MODE;
      pend_mode_q <= RST_MODE;
      pend_q      <= 1'b0;
      de_q        <= 1'b0;
      hsync_q     <= RST_HS;
      vsync_q     <= RST_VS;
      fs_q        <= 1'b0;
      ls_q        <= 1'b0;
    end else begin
      st_q        <= st_d;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      mode_cur_q  <= mode_cur_d;
      pend_mode_q <= pend_mode_d;
      pend_q      <= pend_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      fs_q        <= fs_d;
      ls_q        <= ls_d;
    end
  end

  assign vid.hcount       = hcount_q;
  assign vid.vcount       = vcount_q;
  assign vid.de           = de_q;
  assign vid.hsync        = hsync_q;
  assign vid.vsync        = vsync_q;
  assign vid.frame_start  = fs_q;
  assign vid.line_start   = ls_q;
  assign vid.mode_cur     = mode_cur_q;
  assign vid.mode_pending = pend_q;

  a_fs_implies_ls : assert property (@(posedge clk) disable iff (!rst_n) fs_q |-> ls_q);
  a_pend_differs  : assert property (@(posedge clk) disable iff (!rst_n)
                                     pend_q |-> (pend_mode_q != mode_cur_q));
  a_mode_valid    : assert property (@(posedge clk) disable iff (!rst_n)
                                     32'(mode_cur_q) < NUM_MODES);

endmodule

// File: tb/tb_vid_timing_gen_multi.sv
// Directed bench on reduced-size presets: frame geometry, deferred mode
// switching, idle behaviour and asynchronous reset.
module tb_vid_timing_gen_multi;
  localparam int unsigned CW = 8;

  // mode0: HT=16 (8+2+3+3), VT=8 (4+1+2+1), syncs active-low
  // mode1: HT=14 (10+1+2+1), VT=6 (3+1+1+1), syncs active-high
  // mode2: HT=12 (6+2+2+2),  VT=10 (5+2+1+2), syncs active-high
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vid_timing_gen_multi_if #(.CW(CW)) v0 ();
  vid_timing_gen_multi_if #(.CW(CW)) v1 ();

  vid_timing_gen_multi #(
    .NUM_MODES(3), .CW(CW), .DEFAULT_MODE(0),
    .H_ACTIVE({8'd6, 8'd10, 8'd8}),      .H_FRONT_PORCH({8'd2, 8'd1, 8'd2}),
    .H_SYNC_WIDTH({8'd2, 8'd2, 8'd3}),   .H_BACK_PORCH({8'd2, 8'd1, 8'd3}),
    .V_ACTIVE({8'd5, 8'd3, 8'd4}),       .V_FRONT_PORCH({8'd2, 8'd1, 8'd1}),
    .V_SYNC_WIDTH({8'd1, 8'd1, 8'd2}),   .V_BACK_PORCH({8'd2, 8'd1, 8'd1}),
    .HSYNC_POL(3'b110), .VSYNC_POL(3'b110)
  ) dut0 (.clk(clk), .rst_n(rst_n), .vid(v0));

  vid_timing_gen_multi #(
    .NUM_MODES(2), .CW(CW), .DEFAULT_MODE(1),
    .H_ACTIVE({8'd10, 8'd8}),      .H_FRONT_PORCH({8'd1, 8'd2}),
    .H_SYNC_WIDTH({8'd2, 8'd3}),   .H_BACK_PORCH({8'd1, 8'd3}),
    .V_ACTIVE({8'd3, 8'd4}),       .V_FRONT_PORCH({8'd1, 8'd1}),
    .V_SYNC_WIDTH({8'd1, 8'd2}),   .V_BACK_PORCH({8'd1, 8'd1}),
    .HSYNC_POL(2'b10), .VSYNC_POL(2'b10)
  ) dut1 (.clk(clk), .rst_n(rst_n), .vid(v1));

  function automatic logic [22:0] snap0();
    return {v0.hcount, v0.vcount, v0.de, v0.hsync, v0.vsync, v0.frame_start,
            v0.line_start, v0.mode_cur, v0.mode_pending};
  endfunction

  function automatic logic [22:0] snap1();
    return {v1.hcount, v1.vcount, v1.de, v1.hsync, v1.vsync, v1.frame_start,
            v1.line_start, v1.mode_cur, v1.mode_pending};
  endfunction

  // flags = {de, hsync, vsync, frame_start, line_start}
  function automatic logic [22:0] px(input int h, input int v, input logic [4:0] flags,
                                     input int m, input logic p);
    return {8'(h), 8'(v), flags, 2'(m), p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    repeat (n) step();
  endtask

  task automatic run_frame(output int cyc, output int de_cnt);
    cyc    = 0;
    de_cnt = 0;
    do begin
      if (v0.de) de_cnt++;
      step();
      cyc++;
    end while (v0.frame_start !== 1'b1 && cyc < 1000);
  endtask

  task automatic test_reset();
    logic [22:0] e;
    rst_n = 1'b0;
    v0.enable = 1'b0; v0.mode_sel = 2'd0;
    v1.enable = 1'b0; v1.mode_sel = 2'd1;
    advance(3);
    e = px(0, 0, 5'b01100, 0, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL reset_dut0 got=%h exp=%h", snap0(), e); end
    e = px(0, 0, 5'b00000, 1, 1'b0);
    checks++;
    if (snap1() !== e) begin errors++; $display("FAIL reset_dut1 got=%h exp=%h", snap1(), e); end
  endtask

  task automatic test_first_pixel();
    logic [22:0] e;
    rst_n = 1'b1;
    v0.enable = 1'b1;
    v1.enable = 1'b1;
    step();
    e = px(0, 0, 5'b11111, 0, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL first_px_dut0 got=%h exp=%h", snap0(), e); end
    e = px(0, 0, 5'b10011, 1, 1'b0);
    checks++;
    if (snap1() !== e) begin errors++; $display("FAIL first_px_dut1 got=%h exp=%h", snap1(), e); end
  endtask

  task automatic test_frame_geometry();
    int de0 = 0, hs0 = 0, vs0 = 0, fs0 = 0, ls0 = 0;
    int de1 = 0, hs1 = 0, vs1 = 0, fs1 = 0, ls1 = 0;
    logic [22:0] e;
    for (int i = 0; i < 128; i++) begin
      if (v0.de) de0++;
      if (!v0.hsync) hs0++;
      if (!v0.vsync) vs0++;
      if (v0.frame_start) fs0++;
      if (v0.line_start) ls0++;
      if (i < 84) begin
        if (v1.de) de1++;
        if (v1.hsync) hs1++;
        if (v1.vsync) vs1++;
        if (v1.frame_start) fs1++;
        if (v1.line_start) ls1++;
      end
      if (i == 10) begin
        e = px(10, 0, 5'b00100, 0, 1'b0);
        checks++;
        if (snap0() !== e) begin errors++; $display("FAIL hsync_start_m0 got=%h exp=%h", snap0(), e); end
      end
      if (i == 11) begin
        e = px(11, 0, 5'b01000, 1, 1'b0);
        checks++;
        if (snap1() !== e) begin errors++; $display("FAIL hsync_start_m1 got=%h exp=%h", snap1(), e); end
      end
      if (i == 83) begin
        e = px(13, 5, 5'b00000, 1, 1'b0);
        checks++;
        if (snap1() !== e) begin errors++; $display("FAIL last_px_m1 got=%h exp=%h", snap1(), e); end
      end
      if (i == 127) begin
        e = px(15, 7, 5'b01100, 0, 1'b0);
        checks++;
        if (snap0() !== e) begin errors++; $display("FAIL last_px_m0 got=%h exp=%h", snap0(), e); end
      end
      step();
    end
    checks++;
    if ({de0, hs0, vs0, ls0, fs0} !== {32'd32, 32'd24, 32'd32, 32'd8, 32'd1}) begin
      errors++;
      $display("FAIL counts_m0 got de=%0d hs=%0d vs=%0d ls=%0d fs=%0d exp de=32 hs=24 vs=32 ls=8 fs=1",
               de0, hs0, vs0, ls0, fs0);
    end
    checks++;
    if ({de1, hs1, vs1, ls1, fs1} !== {32'd30, 32'd12, 32'd14, 32'd6, 32'd1}) begin
      errors++;
      $display("FAIL counts_m1 got de=%0d hs=%0d vs=%0d ls=%0d fs=%0d exp de=30 hs=12 vs=14 ls=6 fs=1",
               de1, hs1, vs1, ls1, fs1);
    end
    e = px(0, 0, 5'b11111, 0, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL wrap_m0 got=%h exp=%h", snap0(), e); end
    e = px(2, 3, 5'b00000, 1, 1'b0);
    checks++;
    if (snap1() !== e) begin errors++; $display("FAIL wrap_m1 got=%h exp=%h", snap1(), e); end
  endtask

  task automatic test_mode_change();
    logic [22:0] e;
    int bad = 0;
    int cyc, dec;
    v1.mode_sel = 2'd2;
    advance(35);
    e = px(3, 2, 5'b11100, 0, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL mc_pos got=%h exp=%h", snap0(), e); end
    v0.mode_sel = 2'd2;
    step();
    e = px(4, 2, 5'b11100, 0, 1'b1);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL mc_latch got=%h exp=%h", snap0(), e); end
    for (int i = 37; i < 128; i++) begin
      step();
      if (!(v0.mode_pending === 1'b1 && v0.mode_cur === 2'd0)) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL mc_hold got=%0d bad cycles exp=0", bad); end
    e = px(15, 7, 5'b01100, 0, 1'b1);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL mc_boundary_px got=%h exp=%h", snap0(), e); end
    checks++;
    if ({v1.mode_cur, v1.mode_pending} !== {2'd1, 1'b0}) begin
      errors++;
      $display("FAIL invalid_sel_ignored got=%h exp=%h", {v1.mode_cur, v1.mode_pending}, {2'd1, 1'b0});
    end
    step();
    e = px(0, 0, 5'b10011, 2, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL mc_applied got=%h exp=%h", snap0(), e); end
    run_frame(cyc, dec);
    checks++;
    if (cyc !== 120 || dec !== 30) begin
      errors++;
      $display("FAIL m2_frame got cyc=%0d de=%0d exp cyc=120 de=30", cyc, dec);
    end
    advance(8);
    e = px(8, 0, 5'b01000, 2, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL hsync_start_m2 got=%h exp=%h", snap0(), e); end
    run_frame(cyc, dec);
    checks++;
    if (cyc !== 112) begin errors++; $display("FAIL m2_rest got=%0d exp=112", cyc); end
  endtask

  task automatic test_cancel();
    int cyc, dec;
    v0.mode_sel = 2'd1;
    step();
    checks++;
    if ({v0.mode_cur, v0.mode_pending} !== 3'b101) begin
      errors++; $display("FAIL cancel_latch got=%b exp=101", {v0.mode_cur, v0.mode_pending});
    end
    v0.mode_sel = 2'd3;
    step();
    checks++;
    if ({v0.mode_cur, v0.mode_pending} !== 3'b101) begin
      errors++; $display("FAIL cancel_invalid got=%b exp=101", {v0.mode_cur, v0.mode_pending});
    end
    v0.mode_sel = 2'd2;
    step();
    checks++;
    if ({v0.mode_cur, v0.mode_pending} !== 3'b100) begin
      errors++; $display("FAIL cancel_clear got=%b exp=100", {v0.mode_cur, v0.mode_pending});
    end
    run_frame(cyc, dec);
    checks++;
    if (cyc !== 117 || {v0.mode_cur, v0.mode_pending} !== 3'b100) begin
      errors++;
      $display("FAIL cancel_boundary got cyc=%0d mode=%0d pend=%0d exp cyc=117 mode=2 pend=0",
               cyc, v0.mode_cur, v0.mode_pending);
    end
  endtask

  task automatic test_last_wins();
    logic [22:0] e;
    int cyc, dec;
    v0.mode_sel = 2'd0;
    step();
    v0.mode_sel = 2'd1;
    step();
    advance(117);
    e = px(11, 9, 5'b00000, 2, 1'b1);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL lw_boundary_px got=%h exp=%h", snap0(), e); end
    v0.mode_sel = 2'd0;
    step();
    e = px(0, 0, 5'b10011, 1, 1'b1);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL lw_applied got=%h exp=%h", snap0(), e); end
    run_frame(cyc, dec);
    checks++;
    if (cyc !== 84 || dec !== 30) begin
      errors++;
      $display("FAIL m1_frame got cyc=%0d de=%0d exp cyc=84 de=30", cyc, dec);
    end
    e = px(0, 0, 5'b11111, 0, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL lw_second got=%h exp=%h", snap0(), e); end
  endtask

  task automatic test_enable();
    logic [22:0] e;
    int bad = 0;
    advance(53);
    e = px(5, 3, 5'b11100, 0, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL en_pos got=%h exp=%h", snap0(), e); end
    v0.enable   = 1'b0;
    v0.mode_sel = 2'd1;
    step();
    e = px(0, 0, 5'b01100, 0, 1'b1);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL idle_first got=%h exp=%h", snap0(), e); end
    step();
    e = px(0, 0, 5'b00000, 1, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL idle_apply got=%h exp=%h", snap0(), e); end
    repeat (8) begin
      step();
      if (snap0() !== e) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL idle_hold got=%0d bad cycles exp=0", bad); end
    v0.enable = 1'b1;
    step();
    e = px(0, 0, 5'b10011, 1, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL reenable got=%h exp=%h", snap0(), e); end
    step();
    e = px(1, 0, 5'b10000, 1, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL reenable_next got=%h exp=%h", snap0(), e); end
  endtask

  task automatic test_reset_mid();
    logic [22:0] e;
    advance(20);
    v0.mode_sel = 2'd2;
    step();
    e = px(8, 1, 5'b10000, 1, 1'b1);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL rm_before got=%h exp=%h", snap0(), e); end
    #2;
    rst_n = 1'b0;
    #1;
    e = px(0, 0, 5'b01100, 0, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL rm_async_dut0 got=%h exp=%h", snap0(), e); end
    e = px(0, 0, 5'b00000, 1, 1'b0);
    checks++;
    if (snap1() !== e) begin errors++; $display("FAIL rm_async_dut1 got=%h exp=%h", snap1(), e); end
    v0.mode_sel = 2'd0;
    step();
    rst_n = 1'b1;
    step();
    e = px(0, 0, 5'b11111, 0, 1'b0);
    checks++;
    if (snap0() !== e) begin errors++; $display("FAIL rm_restart_dut0 got=%h exp=%h", snap0(), e); end
    e = px(0, 0, 5'b10011, 1, 1'b0);
    checks++;
    if (snap1() !== e) begin errors++; $display("FAIL rm_restart_dut1 got=%h exp=%h", snap1(), e); end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_frame_geometry();
    test_mode_change();
    test_cancel();
    test_last_wins();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
